// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the program loader. The debug unit and the CPU
// halt detection use the same state encoding, halt word and capacity.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    localparam int          CELLS_DEFAULT     = 256;
    localparam int          WORD_CAPACITY     = CELLS_DEFAULT / 4;
    localparam int          CNT_BITS_DEFAULT  = $clog2(WORD_CAPACITY) + 1;
    localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream in, instruction-memory write port and status out.
// The loader uses the slave view; whoever feeds bytes uses the master view.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int INST_BITS = 32,
    parameter int CNT_BITS  = CNT_BITS_DEFAULT
);
    logic                 i_start;
    logic [NBITS-1:0]     i_rx_data;
    logic                 i_rx_valid;
    logic [INST_BITS-1:0] o_addr_wr;
    logic [INST_BITS-1:0] o_data;
    logic                 o_wr_en;
    logic                 o_step;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic [CNT_BITS-1:0]  o_inst_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_error, o_inst_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_error, o_inst_count
    );
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Packs incoming bytes big-endian into a word. Each accepted byte enters the
// lowest lane and older bytes move up, so the first byte of a word ends up
// in the top lane. o_word is the word as it will look once the current byte
// is accepted, so the caller can capture it in the same cycle as word_ready.
module instruction_loader_byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int INST_BITS = 32
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [NBITS-1:0]     i_byte,
    output logic [INST_BITS-1:0] o_word,
    output logic                 o_word_ready
);
    // Byte counter width assumes a power-of-two number of bytes per word,
    // so the counter wraps back to 0 by itself after the last byte.
    localparam int            BYTES     = INST_BITS / NBITS;
    localparam int            CW        = $clog2(BYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

    logic [BYTES-1:0][NBITS-1:0] lane_reg;
    logic [BYTES-1:0][NBITS-1:0] lane_next;
    logic [CW-1:0]               cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_in
                assign lane_next[gi] = i_byte;
            end else begin : g_shift
                assign lane_next[gi] = lane_reg[gi-1];
            end
        end
    endgenerate

    assign o_word       = lane_next;
    assign o_word_ready = i_accept && (cnt_reg == LAST_BYTE);

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            lane_reg <= '0;
            cnt_reg  <= '0;
        end else if (i_accept) begin
            lane_reg <= lane_next;
            cnt_reg  <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Program loader: receives bytes from the UART, writes 32-bit words to
// consecutive instruction-memory addresses from 0, and stops on the halt
// word or when memory is full. All outputs come straight from registers so
// the memory's falling-edge write sees values stable for the whole cycle.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int                   NBITS     = 8,
    parameter int                   INST_BITS = 32,
    parameter int                   CELLS     = CELLS_DEFAULT,
    parameter logic [INST_BITS-1:0] HALT_INST = INST_BITS'(HALT_INST_DEFAULT),
    parameter int                   CNT_BITS  = $clog2(CELLS / 4) + 1
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    instruction_loader_if.slave   bus
);
    localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - 4);
    localparam logic [INST_BITS-1:0] ADDR_STEP = INST_BITS'(4);

    load_state_t          state_reg, state_next;
    logic [INST_BITS-1:0] addr_reg, addr_next;
    logic [INST_BITS-1:0] addr_wr_reg, addr_wr_next;
    logic [INST_BITS-1:0] data_reg, data_next;
    logic                 wr_en_reg, wr_en_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 error_reg, error_next;
    logic [CNT_BITS-1:0]  count_reg, count_next;

    logic                 asm_clear;
    logic                 asm_accept;
    logic [INST_BITS-1:0] asm_word;
    logic                 asm_word_ready;

    instruction_loader_byte_assembler #(
        .NBITS     (NBITS),
        .INST_BITS (INST_BITS)
    ) u_assembler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (asm_clear),
        .i_accept     (asm_accept),
        .i_byte       (bus.i_rx_data),
        .o_word       (asm_word),
        .o_word_ready (asm_word_ready)
    );

    // Next state and next output values. The write is registered on the
    // edge that accepts the 4th byte, so WRITE is the cycle the strobe is
    // visible; the halt/full decision is taken on the word held in data_reg.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        addr_wr_next = addr_wr_reg;
        data_next    = data_reg;
        wr_en_next   = 1'b0;
        done_next    = done_reg;
        error_next   = error_reg;
        count_next   = count_reg;
        asm_clear    = 1'b0;
        asm_accept   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_next   = ST_RECV;
                    addr_next    = '0;
                    addr_wr_next = '0;
                    count_next   = '0;
                    done_next    = 1'b0;
                    error_next   = 1'b0;
                    asm_clear    = 1'b1;
                end
            end
            ST_RECV: begin
                asm_accept = bus.i_rx_valid;
                if (asm_word_ready) begin
                    state_next   = ST_WRITE;
                    wr_en_next   = 1'b1;
                    addr_wr_next = addr_reg;
                    data_next    = asm_word;
                    count_next   = count_reg + CNT_BITS'(1);
                end
            end
            ST_WRITE: begin
                if (data_reg == HALT_INST) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else if (addr_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                end else begin
                    // A byte arriving now is the first byte of the next word.
                    state_next = ST_RECV;
                    addr_next  = addr_reg + ADDR_STEP;
                    asm_accept = bus.i_rx_valid;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_RECV) || (state_next == ST_WRITE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            addr_wr_reg <= '0;
            data_reg    <= '0;
            wr_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            addr_wr_reg <= addr_wr_next;
            data_reg    <= data_next;
            wr_en_reg   <= wr_en_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
            count_reg   <= count_next;
        end
    end

    assign bus.o_addr_wr    = addr_wr_reg;
    assign bus.o_data       = data_reg;
    assign bus.o_wr_en      = wr_en_reg;
    assign bus.o_step       = wr_en_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_done       = done_reg;
    assign bus.o_error      = error_reg;
    assign bus.o_inst_count = count_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for the program loader: table of short programs with hand-computed
// results, hand-written multi-cycle sequences, and random programs checked
// against a word-level model of the load rules.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] words [4];
        int          nwords;
        int          gap;
        int          exp_count;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_loader_if bus ();

    instruction_loader dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    wr_t  got_wr [$];
    wr_t  exp_wr [$];
    bit   exp_done;
    bit   exp_err;
    int   exp_cnt;
    logic [7:0] prog [$];
    vec_t tbl [5];

    // Capture every write strobe; o_step must always follow o_wr_en.
    always @(negedge clk) begin
        if (bus.o_wr_en === 1'b1 || bus.o_step === 1'b1) begin
            checks++;
            if (bus.o_step !== bus.o_wr_en) begin
                errors++;
                $display("FAIL step_vs_wr_en: step=%0b wr_en=%0b", bus.o_step, bus.o_wr_en);
            end
            if (bus.o_wr_en === 1'b1)
                got_wr.push_back('{bus.o_addr_wr, bus.o_data});
        end
    end

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        repeat (2) tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        bus.i_start = 1'b1;
        tick;
        bus.i_start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    // gap < 0 picks a random idle gap after each byte.
    task automatic send_prog(input int gap);
        int g;
        foreach (prog[i]) begin
            bus.i_rx_data  = prog[i];
            bus.i_rx_valid = 1'b1;
            tick;
            bus.i_rx_valid = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) tick;
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (bus.o_done !== 1'b1 && k < 12) begin
            tick;
            k++;
        end
        check(name, {95'd0, bus.o_done}, 96'd1);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {20'd0, bus.o_addr_wr, bus.o_data, bus.o_wr_en, bus.o_step,
                     bus.o_busy, bus.o_done, bus.o_error, bus.o_inst_count}, 96'd0);
    endtask

    // Word-level model: bytes form big-endian words written to 0,4,8,...;
    // the load ends after the halt word or after the 64th word.
    task automatic model;
        logic [31:0] w = 32'd0;
        int nb = 0;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        foreach (prog[i]) begin
            if (exp_done) break;
            w = {w[23:0], prog[i]};
            nb++;
            if (nb == 4) begin
                nb = 0;
                exp_wr.push_back('{32'(exp_cnt * 4), w});
                exp_cnt++;
                if (w == 32'hFFFF_FFFF) exp_done = 1'b1;
                else if (exp_cnt == WORD_CAPACITY) begin
                    exp_done = 1'b1;
                    exp_err  = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nwrites"}, 96'(got_wr.size()), 96'(exp_wr.size()));
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {32'd0, got_wr[i]}, {32'd0, exp_wr[i]});
        check({tag, "_done"},  {95'd0, bus.o_done},  {95'd0, exp_done});
        check({tag, "_error"}, {95'd0, bus.o_error}, {95'd0, exp_err});
        check({tag, "_count"}, 96'(bus.o_inst_count), 96'(exp_cnt));
    endtask

    initial begin
        tbl[0] = '{words: '{32'h2008_0005, 32'hFFFF_FFFF, 0, 0}, nwords: 2, gap: 2,
                   exp_count: 2, exp_addr: 32'd4, exp_data: 32'hFFFF_FFFF, exp_done: 1, exp_err: 0};
        tbl[1] = '{words: '{32'hFFFF_FFFF, 0, 0, 0}, nwords: 1, gap: 0,
                   exp_count: 1, exp_addr: 32'd0, exp_data: 32'hFFFF_FFFF, exp_done: 1, exp_err: 0};
        tbl[2] = '{words: '{32'h1122_3344, 32'h5566_7788, 32'hFFFF_FFFF, 0}, nwords: 3, gap: 0,
                   exp_count: 3, exp_addr: 32'd8, exp_data: 32'hFFFF_FFFF, exp_done: 1, exp_err: 0};
        tbl[3] = '{words: '{32'hFFFF_FFFF, 32'h1234_5678, 0, 0}, nwords: 2, gap: 0,
                   exp_count: 1, exp_addr: 32'd0, exp_data: 32'hFFFF_FFFF, exp_done: 1, exp_err: 0};
        tbl[4] = '{words: '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0}, nwords: 3, gap: 1,
                   exp_count: 3, exp_addr: 32'd8, exp_data: 32'hFFFF_FFFF, exp_done: 1, exp_err: 0};

        do_reset;
        check_outputs_zero("reset_state");

        // Table of short programs.
        for (int t = 0; t < 5; t++) begin
            prog.delete();
            for (int w = 0; w < tbl[t].nwords; w++) push_word(tbl[t].words[w]);
            got_wr.delete();
            pulse_start;
            send_prog(tbl[t].gap);
            wait_done($sformatf("tbl%0d_done_wait", t));
            repeat (2) tick;
            check($sformatf("tbl%0d_nwrites", t), 96'(got_wr.size()), 96'(tbl[t].exp_count));
            if (got_wr.size() > 0) begin
                check($sformatf("tbl%0d_last_addr", t), 96'(got_wr[$].addr), 96'(tbl[t].exp_addr));
                check($sformatf("tbl%0d_last_data", t), 96'(got_wr[$].data), 96'(tbl[t].exp_data));
            end
            check($sformatf("tbl%0d_count", t), 96'(bus.o_inst_count), 96'(tbl[t].exp_count));
            check($sformatf("tbl%0d_done", t),  {95'd0, bus.o_done},  {95'd0, tbl[t].exp_done});
            check($sformatf("tbl%0d_error", t), {95'd0, bus.o_error}, {95'd0, tbl[t].exp_err});
            check($sformatf("tbl%0d_busy", t),  {95'd0, bus.o_busy},  96'd0);
            $display("table vector %0d: writes=%0d count=%0d done=%0b error=%0b",
                     t, got_wr.size(), bus.o_inst_count, bus.o_done, bus.o_error);
        end

        // Memory full: 65 zero words, the last must not be written.
        prog.delete();
        for (int w = 0; w < 65; w++) push_word(32'h0000_0000);
        got_wr.delete();
        pulse_start;
        send_prog(0);
        repeat (4) tick;
        check("full_nwrites", 96'(got_wr.size()), 96'd64);
        check("full_last_addr", 96'(got_wr[$].addr), 96'd252);
        check("full_first_addr", 96'(got_wr[0].addr), 96'd0);
        check("full_error", {95'd0, bus.o_error}, 96'd1);
        check("full_done", {95'd0, bus.o_done}, 96'd1);
        check("full_count", 96'(bus.o_inst_count), 96'd64);
        $display("memory full: writes=%0d last_addr=%0d error=%0b", got_wr.size(), got_wr[$].addr, bus.o_error);

        // Reset after two bytes discards the partial word.
        pulse_start;
        prog = '{8'hAA, 8'hBB};
        send_prog(0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_outputs_zero("midreset_outputs");
        got_wr.delete();
        pulse_start;
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_prog(0);
        repeat (3) tick;
        check("midreset_nwrites", 96'(got_wr.size()), 96'd1);
        check("midreset_wr0", {32'd0, got_wr[0]}, {32'd0, 32'd0, 32'h1122_3344});
        check("midreset_busy", {95'd0, bus.o_busy}, 96'd1);
        check("midreset_not_done", {95'd0, bus.o_done}, 96'd0);
        prog.delete();
        push_word(32'hFFFF_FFFF);
        send_prog(1);
        wait_done("midreset_done_wait");
        check("midreset_count", 96'(bus.o_inst_count), 96'd2);
        $display("reset mid-load: writes=%0d first=%0h", got_wr.size(), got_wr[0].data);

        // i_start during RECV is ignored; the word keeps its address.
        got_wr.delete();
        pulse_start;
        prog.delete();
        push_word(32'hAABB_CCDD);
        prog.push_back(8'h12);
        send_prog(0);
        pulse_start;
        prog = '{8'h34, 8'h56, 8'h78};
        push_word(32'hFFFF_FFFF);
        send_prog(0);
        wait_done("start_in_recv_done_wait");
        repeat (2) tick;
        check("start_in_recv_nwrites", 96'(got_wr.size()), 96'd3);
        check("start_in_recv_wr1", {32'd0, got_wr[1]}, {32'd0, 32'd4, 32'h1234_5678});
        check("start_in_recv_count", 96'(bus.o_inst_count), 96'd3);
        $display("start during RECV: wr1 addr=%0d data=%0h", got_wr[1].addr, got_wr[1].data);

        // Restart from DONE.
        got_wr.delete();
        pulse_start;
        check("restart_done_falls", {95'd0, bus.o_done}, 96'd0);
        check("restart_busy", {95'd0, bus.o_busy}, 96'd1);
        check("restart_count_clear", 96'(bus.o_inst_count), 96'd0);
        prog.delete();
        push_word(32'hFFFF_FFFF);
        send_prog(0);
        wait_done("restart_done_wait");
        check("restart_nwrites", 96'(got_wr.size()), 96'd1);
        check("restart_wr0", {32'd0, got_wr[0]}, {32'd0, 32'd0, 32'hFFFF_FFFF});
        check("restart_count", 96'(bus.o_inst_count), 96'd1);
        $display("restart from DONE: count=%0d done=%0b", bus.o_inst_count, bus.o_done);

        // Random programs against the model.
        for (int r = 0; r < 20; r++) begin
            int n;
            int tail;
            logic [31:0] w;
            prog.delete();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = 32'h0;
                push_word(w);
            end
            push_word(32'hFFFF_FFFF);
            tail = $urandom_range(0, 5);
            for (int k = 0; k < tail; k++) prog.push_back(8'($urandom));
            model();
            got_wr.delete();
            pulse_start;
            send_prog(($urandom_range(0, 1) == 0) ? 0 : -1);
            wait_done($sformatf("rand%0d_done_wait", r));
            repeat (2) tick;
            compare_model($sformatf("rand%0d", r));
            $display("random program %0d: bytes=%0d writes=%0d expected=%0d",
                     r, prog.size(), got_wr.size(), exp_wr.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Program loader that sits directly upstream of the instruction memory write port.
- Receives a program as a stream of bytes from the UART receiver.
- Assembles the bytes big-endian into 32-bit words and writes them to consecutive word addresses starting at 0.
- Stops at the HALT word or when memory is full, then flags completion to the debug unit.

Parameters:
NBITS, 8, width of a received byte and of one memory cell
INST_BITS, 32, instruction and address width
CELLS, 256, instruction memory size in bytes; capacity is CELLS/4 words
HALT_INST, 32'hFFFF_FFFF, word that terminates the load; it is itself written
CNT_BITS, $clog2(CELLS/4)+1, width of the word counter (7 at the defaults)

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  reset, synchronous and active-high
i_start  in  1  single-cycle pulse; starts a load from IDLE or DONE
i_rx_data  in  NBITS  byte from the UART receiver
i_rx_valid  in  1  single-cycle pulse; i_rx_data is valid this cycle
o_addr_wr  out  INST_BITS  byte address of the word being written (multiple of 4)
o_data  out  INST_BITS  assembled instruction word
o_wr_en  out  1  write strobe into instruction memory
o_step  out  1  enable into instruction memory; asserted together with o_wr_en
o_busy  out  1  high in RECV and WRITE
o_done  out  1  load finished; held until the next i_start or reset
o_error  out  1  memory filled without HALT_INST; held like o_done
o_inst_count  out  CNT_BITS  number of words written in the current load

Behaviour:
- All outputs are registered. Every output is 0 after reset.
- Write outputs are stable for the whole cycle, so the memory's falling-edge write samples them mid-cycle.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Bytes are ignored.
  - i_start -> RECV. On entry: word address = 0, byte count = 0, shift register = 0, o_inst_count = 0, o_done = 0, o_error = 0.
- RECV:
  - On i_rx_valid: shift <= {shift[23:0], i_rx_data}; byte count += 1.
  - The first byte received ends up in bits [31:24] (big-endian).
  - When the 4th byte is accepted -> WRITE. The byte count wraps to 0.
- WRITE (exactly one cycle):
  - o_wr_en = o_step = 1, o_addr_wr = current address, o_data = assembled word, o_inst_count += 1.
  - Next cycle o_wr_en and o_step return to 0.
  - If word == HALT_INST -> DONE, o_done = 1.
  - Else if address == CELLS-4 -> DONE, o_done = 1, o_error = 1.
  - Else address += 4 -> RECV.
- Byte arriving during WRITE:
  - Accepted as byte 0 of the next word; no byte is lost.
  - If the state then goes to DONE, that byte is discarded.
- DONE:
  - Bytes are ignored.
  - o_done, o_error, o_inst_count and o_addr_wr hold their values.
  - i_start restarts exactly as from IDLE.
- i_start while in RECV or WRITE: ignored.
- Reset mid-load:
  - Next state is IDLE, all outputs 0, any partial word discarded.
  - Words already written remain in memory; this block does not clear them.
- Back-to-back i_rx_valid on every cycle is supported. The latency from the 4th byte to o_wr_en is 1 cycle.
- Address arithmetic is INST_BITS wide. The address never exceeds CELLS-4, so no wrap-around occurs.

Decomposition:
- Shared package: the state encoding (IDLE/RECV/WRITE/DONE), the HALT_INST value, and the capacity localparam CELLS/4. The debug unit and the CPU halt detection reuse them.
- One natural sub-module: byte_assembler (shift register plus 2-bit byte counter, outputs word and word_ready). The FSM and address counter stay in the top module.

Test Plan:
1. Reset, i_start, then bytes 20 08 00 05, FF FF FF FF -> two write cycles: (addr 0, 0x20080005) then (addr 4, 0xFFFFFFFF); o_done=1, o_error=0, o_inst_count=2.
2. 64 non-halt words (e.g. 0x00000000) -> 64 writes at addresses 0..252; o_done=1, o_error=1, o_inst_count=64. A 65th word produces no o_wr_en.
3. i_rx_valid on every cycle for 12 bytes, the 9th byte landing in a WRITE cycle -> three correct words, none shifted by one byte.
4. After 2 bytes (AA BB), assert i_rst for one cycle, then i_start and bytes 11 22 33 44 -> single write at addr 0 of 0x11223344.
5. i_start pulse during RECV after 1 byte -> ignored; the word completes normally at the original address.
6. From DONE, i_start and a one-word HALT program -> o_done falls on start, write at addr 0, o_done rises again, o_inst_count=1.
